// File: rtl/exe_issue_units_if.sv
// exe_issue_units_if: issue handshake, load memory port and per-unit result buses
// of the execute stage; master is the decode/EXE-WB side, slave is the execute block.
interface exe_issue_units_if #(
    parameter int NREGS = 16
);
    localparam int RW = $clog2(NREGS);
    logic             issue_valid;
    logic [1:0]       issue_unit;
    logic [1:0]       issue_op;
    logic [RW-1:0]    issue_Rd;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             issue_ready;
    logic [NREGS-1:0] pending;
    logic             mem_rd;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_rdata;
    logic [3:0]       wr_allow;
    logic [RW-1:0]    alu_Rd;
    logic [RW-1:0]    ld_Rd;
    logic [RW-1:0]    mul_Rd;
    logic [RW-1:0]    div_Rd;
    logic [31:0]      alu_exe;
    logic [31:0]      ld_exe;
    logic [31:0]      mul_exe;
    logic [31:0]      div_exe;
    modport master (
        output issue_valid, issue_unit, issue_op, issue_Rd, op_a, op_b, mem_rdata,
        input  issue_ready, pending, mem_rd, mem_addr, wr_allow,
        input  alu_Rd, ld_Rd, mul_Rd, div_Rd, alu_exe, ld_exe, mul_exe, div_exe
    );
    modport slave (
        input  issue_valid, issue_unit, issue_op, issue_Rd, op_a, op_b, mem_rdata,
        output issue_ready, pending, mem_rd, mem_addr, wr_allow,
        output alu_Rd, ld_Rd, mul_Rd, div_Rd, alu_exe, ld_exe, mul_exe, div_exe
    );
endinterface

// File: rtl/exe_issue_units.sv
// exe_issue_units: routes one instruction per cycle to ALU/LD/MUL/DIV, keeps a
// destination scoreboard and presents registered per-unit result strobes.
module exe_issue_units #(
    parameter int MUL_STAGES = 3,
    parameter int NREGS = 16
) (
    input logic clk,
    input logic rst_n,
    exe_issue_units_if.slave io
);
    localparam int RW = $clog2(NREGS);
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
    div_state_t state, state_n;
    logic [NREGS-1:0] pending_q, set_m, clr_m;
    logic unit_ok, accept, acc_alu, acc_ld, acc_mul, acc_div;
    logic alu_v, mem_rd_q, ld_v, div_v, div_fin, ge, dz;
    logic [RW-1:0] alu_rd, ld_rd_q, ld_rd, div_rd_q, div_rd;
    logic [31:0] alu_res, alu_exe, mem_addr_q, ld_exe, div_exe;
    logic [MUL_STAGES-1:0] mv;
    logic [RW-1:0] mr [MUL_STAGES];
    logic [31:0] md [MUL_STAGES];
    logic [31:0] dq, drem, ddiv, rem_n, q_n;
    logic [32:0] shifted;
    logic [4:0] dcnt;
    // LD stays busy through both the mem_rd cycle and the strobe cycle
    assign unit_ok = io.issue_unit == 2'd1 ? !(mem_rd_q || ld_v) :
                     io.issue_unit == 2'd3 ? state != DIV_RUN : 1'b1;
    assign io.issue_ready = unit_ok && !pending_q[io.issue_Rd];
    assign accept = io.issue_valid && io.issue_ready;
    assign acc_alu = accept && io.issue_unit == 2'd0;
    assign acc_ld = accept && io.issue_unit == 2'd1;
    assign acc_mul = accept && io.issue_unit == 2'd2;
    assign acc_div = accept && io.issue_unit == 2'd3;
    assign alu_res = io.issue_op == 2'd0 ? io.op_a + io.op_b :
                     io.issue_op == 2'd1 ? io.op_a - io.op_b :
                     io.issue_op == 2'd2 ? io.op_a & io.op_b : io.op_a | io.op_b;
    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (accept) set_m[io.issue_Rd] = 1'b1;
        if (alu_v) clr_m[alu_rd] = 1'b1;
        if (ld_v) clr_m[ld_rd] = 1'b1;
        if (mv[MUL_STAGES-1]) clr_m[mr[MUL_STAGES-1]] = 1'b1;
        if (div_v) clr_m[div_rd] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pending_q <= '0;
        else pending_q <= (pending_q & ~clr_m) | set_m;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_v <= 1'b0;
            alu_rd <= '0;
            alu_exe <= '0;
        end else begin
            alu_v <= acc_alu;
            if (acc_alu) begin
                alu_rd <= io.issue_Rd;
                alu_exe <= alu_res;
            end
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mem_rd_q <= 1'b0;
            mem_addr_q <= '0;
            ld_rd_q <= '0;
            ld_v <= 1'b0;
            ld_rd <= '0;
            ld_exe <= '0;
        end else begin
            mem_rd_q <= acc_ld;
            ld_v <= mem_rd_q;
            if (acc_ld) begin
                mem_addr_q <= io.op_a + io.op_b;
                ld_rd_q <= io.issue_Rd;
            end
            if (mem_rd_q) begin
                ld_rd <= ld_rd_q;
                ld_exe <= io.mem_rdata;
            end
        end
    // stages advance only behind a valid so the last stage holds when idle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mv <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                mr[i] <= '0;
                md[i] <= '0;
            end
        end else begin
            mv <= MUL_STAGES'({mv, acc_mul});
            if (acc_mul) begin
                mr[0] <= io.issue_Rd;
                md[0] <= io.op_a * io.op_b;
            end
            for (int i = 1; i < MUL_STAGES; i++)
                if (mv[i-1]) begin
                    mr[i] <= mr[i-1];
                    md[i] <= md[i-1];
                end
        end
    always_comb begin
        shifted = {drem, dq[31]};
        ge = shifted >= {1'b0, ddiv};
        rem_n = ge ? 32'(shifted - {1'b0, ddiv}) : shifted[31:0];
        q_n = {dq[30:0], ge};
        dz = ddiv == '0;
        state_n = state == DIV_RUN ? ((dz || dcnt == '0) ? DIV_DONE : DIV_RUN) :
                  (acc_div ? DIV_RUN : DIV_IDLE);
        div_fin = state == DIV_RUN && state_n == DIV_DONE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= DIV_IDLE;
        else state <= state_n;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dq <= '0;
            drem <= '0;
            ddiv <= '0;
            dcnt <= '0;
            div_rd_q <= '0;
            div_v <= 1'b0;
            div_rd <= '0;
            div_exe <= '0;
        end else begin
            div_v <= div_fin;
            if (acc_div) begin
                dq <= io.op_a;
                ddiv <= io.op_b;
                drem <= '0;
                dcnt <= 5'd31;
                div_rd_q <= io.issue_Rd;
            end else if (state == DIV_RUN) begin
                dq <= q_n;
                drem <= rem_n;
                dcnt <= dcnt - 5'd1;
            end
            if (div_fin) begin
                div_rd <= div_rd_q;
                div_exe <= dz ? '1 : q_n;
            end
        end
    assign io.pending = pending_q;
    assign io.mem_rd = mem_rd_q;
    assign io.mem_addr = mem_addr_q;
    assign io.wr_allow = {alu_v, ld_v, mv[MUL_STAGES-1], div_v};
    assign io.alu_Rd = alu_rd;
    assign io.ld_Rd = ld_rd;
    assign io.mul_Rd = mr[MUL_STAGES-1];
    assign io.div_Rd = div_rd;
    assign io.alu_exe = alu_exe;
    assign io.ld_exe = ld_exe;
    assign io.mul_exe = md[MUL_STAGES-1];
    assign io.div_exe = div_exe;
endmodule

// File: tb/tb_exe_issue_units.sv
// tb_exe_issue_units: randomized and directed issue stream; a cycle-indexed model
// predicts every strobe, pending bit and issue_ready, and a monitor pops and compares.
module tb_exe_issue_units;
    localparam int MS = 3;
    typedef struct { int cyc; logic [3:0] rd; logic [31:0] val; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ld_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    exp_t eq [4][$];
    ld_t ldq [$];
    int ri [16];
    int rs [16];
    int ld_s, div_s;
    logic [3:0] mon_w;
    logic [15:0] mon_p;
    logic [3:0] mon_rd;
    logic [31:0] mon_val;
    exp_t mon_e;
    ld_t mem_e;
    exe_issue_units_if #(.NREGS(16)) bus();
    exe_issue_units #(.MUL_STAGES(MS), .NREGS(16)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask
    function automatic logic pend_at(int r, int t);
        return t > ri[r] && t <= rs[r];
    endfunction
    task automatic clear_model();
        for (int r = 0; r < 16; r++) begin
            ri[r] = -1;
            rs[r] = -1;
        end
        ld_s = -1;
        div_s = -1;
        for (int u = 0; u < 4; u++) eq[u].delete();
        ldq.delete();
    endtask
    task automatic chk_zero();
        chk("rst_wr_allow", 32'(bus.wr_allow), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_alu_exe", bus.alu_exe, 0);
        chk("rst_ld_exe", bus.ld_exe, 0);
        chk("rst_mul_exe", bus.mul_exe, 0);
        chk("rst_div_exe", bus.div_exe, 0);
        chk("rst_rds", 32'({bus.alu_Rd, bus.ld_Rd, bus.mul_Rd, bus.div_Rd}), 0);
    endtask
    task automatic idle(input int n);
        bus.issue_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    // called at posedge+1; drives one attempt for the current cycle
    task automatic issue(input logic [1:0] u, input logic [1:0] op, input logic [3:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] md);
        exp_t e;
        ld_t l;
        logic ok;
        int lat;
        bus.issue_valid = 1'b1;
        bus.issue_unit = u;
        bus.issue_op = op;
        bus.issue_Rd = rd;
        bus.op_a = a;
        bus.op_b = b;
        #1;
        ok = !pend_at(int'(rd), cyc) && (u == 2'd1 ? cyc > ld_s : u == 2'd3 ? cyc >= div_s : 1'b1);
        chk("issue_ready", 32'(bus.issue_ready), 32'(ok));
        if (ok) begin
            lat = u == 2'd0 ? 1 : u == 2'd1 ? 2 : u == 2'd2 ? MS : (b == 0 ? 2 : 33);
            e.cyc = cyc + lat;
            e.rd = rd;
            e.val = u == 2'd0 ? (op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a | b) :
                    u == 2'd1 ? md : u == 2'd2 ? a * b : (b == 0 ? 32'hFFFF_FFFF : a / b);
            eq[u].push_back(e);
            ri[rd] = cyc;
            rs[rd] = cyc + lat;
            if (u == 2'd1) begin
                ld_s = cyc + lat;
                l.addr = a + b;
                l.data = md;
                ldq.push_back(l);
            end
            if (u == 2'd3) div_s = cyc + lat;
        end
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
    endtask
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.mem_rd) begin
            if (ldq.size() > 0) begin
                mem_e = ldq.pop_front();
                chk("mem_addr", bus.mem_addr, mem_e.addr);
                bus.mem_rdata = mem_e.data;
            end else chk("mem_rd", 32'(bus.mem_rd), 0);
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            mon_w = '0;
            for (int u = 0; u < 4; u++)
                if (eq[u].size() > 0 && eq[u][0].cyc == cyc) mon_w[3-u] = 1'b1;
            chk("wr_allow", 32'(bus.wr_allow), 32'(mon_w));
            for (int u = 0; u < 4; u++)
                while (eq[u].size() > 0 && eq[u][0].cyc <= cyc) begin
                    mon_e = eq[u].pop_front();
                    mon_rd = u == 0 ? bus.alu_Rd : u == 1 ? bus.ld_Rd : u == 2 ? bus.mul_Rd : bus.div_Rd;
                    mon_val = u == 0 ? bus.alu_exe : u == 1 ? bus.ld_exe : u == 2 ? bus.mul_exe : bus.div_exe;
                    if (bus.wr_allow[3-u]) begin
                        chk("result_rd", 32'(mon_rd), 32'(mon_e.rd));
                        chk("result_val", mon_val, mon_e.val);
                    end
                end
            for (int r = 0; r < 16; r++) mon_p[r] = pend_at(r, cyc);
            chk("pending", 32'(bus.pending), 32'(mon_p));
        end
    end
    initial begin
        clear_model();
        bus.issue_valid = 1'b0;
        bus.issue_unit = '0;
        bus.issue_op = '0;
        bus.issue_Rd = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // reset in the middle of a divide aborts it silently
        issue(2'd3, 2'd0, 4'd5, 32'd100, 32'd7, 32'd0);
        idle(9);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero();
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(40);
        issue(2'd0, 2'd1, 4'd2, 32'd3, 32'd5, 32'd0);
        idle(3);
        issue(2'd1, 2'd0, 4'd7, 32'h100, 32'h24, 32'hDEAD_BEEF);
        idle(4);
        issue(2'd2, 2'd0, 4'd1, 32'h1_0000, 32'h1_0000, 32'd0);
        issue(2'd2, 2'd0, 4'd3, 32'd7, 32'd6, 32'd0);
        issue(2'd2, 2'd0, 4'd4, 32'hFFFF_FFFF, 32'd2, 32'd0);
        idle(5);
        issue(2'd3, 2'd0, 4'd9, 32'd100, 32'd7, 32'd0);
        issue(2'd3, 2'd0, 4'd10, 32'd1, 32'd1, 32'd0);
        issue(2'd0, 2'd0, 4'd9, 32'd1, 32'd1, 32'd0);
        issue(2'd0, 2'd3, 4'd8, 32'hF0, 32'h0F, 32'd0);
        idle(35);
        issue(2'd3, 2'd0, 4'd6, 32'd5, 32'd0, 32'd0);
        idle(4);
        issue(2'd2, 2'd0, 4'd1, 32'd3, 32'd4, 32'd0);
        idle(1);
        issue(2'd0, 2'd2, 4'd2, 32'hFF00, 32'h0FF0, 32'd0);
        idle(5);
        for (int i = 0; i < 400; i++) begin
            logic [1:0] u;
            u = 2'($urandom_range(0, 3));
            issue(u, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
                  (u == 2'd3 && $urandom_range(0, 3) == 0) ? 32'd0 :
                  (u == 2'd3 ? 32'($urandom_range(1, 1000)) : $urandom), $urandom);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(50);
        chk("drain", 32'(eq[0].size() + eq[1].size() + eq[2].size() + eq[3].size() + ldq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
